// File: rtl/exibe_sequencia_pkg.sv
// Shared state codes and helpers for the LED sequence presenter.
// The state codes double as the hexa7seg debug values.
package exibe_sequencia_pkg;

  localparam logic [3:0] EST_INICIAL = 4'h0;
  localparam logic [3:0] EST_PREPARA = 4'h1;
  localparam logic [3:0] EST_ACENDE  = 4'h2;
  localparam logic [3:0] EST_APAGA   = 4'h3;
  localparam logic [3:0] EST_PROXIMO = 4'h4;
  localparam logic [3:0] EST_FIM     = 4'hF;

  localparam logic [3:0] LED_APAGADO = 4'b0000;

  typedef enum logic [3:0] {
    INICIAL = EST_INICIAL,
    PREPARA = EST_PREPARA,
    ACENDE  = EST_ACENDE,
    APAGA   = EST_APAGA,
    PROXIMO = EST_PROXIMO,
    FIM     = EST_FIM
  } estado_t;

  function automatic int maximo(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/exibe_sequencia_contador_m.sv
// Modulo-M up counter with synchronous clear; used as the on/off phase timer.
module contador_m #(
  parameter int M = 1000,
  parameter int W = 10
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         zera,
  input  logic         conta,
  output logic [W-1:0] q,
  output logic         fim
);

  logic [W-1:0] r_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_q <= '0;
    end else if (zera) begin
      r_q <= '0;
    end else if (conta) begin
      r_q <= (r_q == W'(M - 1)) ? '0 : r_q + 1'b1;
    end
  end

  assign q   = r_q;
  assign fim = (r_q == W'(M - 1));

endmodule

// File: rtl/exibe_sequencia.sv
// Presents the stored sequence on the leds, item 0..limite, each lit T_ON cycles
// followed by a T_OFF dark gap, then pulses pronto for one cycle.
module exibe_sequencia
  import exibe_sequencia_pkg::*;
#(
  parameter int T_ON  = 1000,
  parameter int T_OFF = 500
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       parar,
  input  logic [3:0] limite,
  input  logic [3:0] mem_dado,
  output logic [3:0] mem_endereco,
  output logic [3:0] leds,
  output logic       exibindo,
  output logic       pronto,
  output logic [3:0] db_estado
);

  localparam int M = maximo(T_ON, T_OFF);
  localparam int W = $clog2(M);
  localparam logic [W-1:0] C_FIM_ON  = W'(T_ON - 1);
  localparam logic [W-1:0] C_FIM_OFF = W'(T_OFF - 1);

  estado_t    r_estado;
  estado_t    w_proximo;
  logic [3:0] r_endereco;
  logic [3:0] r_limite;
  logic [3:0] r_leds;

  logic         w_zera;
  logic         w_conta;
  logic         w_carrega;
  logic         w_captura;
  logic         w_incrementa;
  logic [W-1:0] w_contagem;
  logic         w_fim_contador;
  logic         w_fim_on;
  logic         w_fim_off;

  contador_m #(.M(M), .W(W)) u_temporizador (
    .clock (clock),
    .reset (reset),
    .zera  (w_zera),
    .conta (w_conta),
    .q     (w_contagem),
    .fim   (w_fim_contador)
  );

  // The longer phase ends exactly when the counter reaches its modulus.
  assign w_fim_on  = (T_ON  == M) ? w_fim_contador : (w_contagem == C_FIM_ON);
  assign w_fim_off = (T_OFF == M) ? w_fim_contador : (w_contagem == C_FIM_OFF);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_estado <= INICIAL;
    end else begin
      r_estado <= w_proximo;
    end
  end

  always_comb begin
    w_proximo    = r_estado;
    w_zera       = 1'b0;
    w_conta      = 1'b0;
    w_carrega    = 1'b0;
    w_captura    = 1'b0;
    w_incrementa = 1'b0;
    if (parar) begin
      w_proximo = INICIAL;
      w_zera    = 1'b1;
    end else begin
      case (r_estado)
        INICIAL: begin
          if (iniciar) begin
            w_proximo = PREPARA;
            w_carrega = 1'b1;
            w_zera    = 1'b1;
          end
        end
        PREPARA: begin
          w_captura = 1'b1;
          w_proximo = ACENDE;
        end
        ACENDE: begin
          if (w_fim_on) begin
            w_zera    = 1'b1;
            w_proximo = APAGA;
          end else begin
            w_conta = 1'b1;
          end
        end
        APAGA: begin
          if (w_fim_off) begin
            w_zera = 1'b1;
            if (r_endereco == r_limite) begin
              w_proximo = FIM;
            end else begin
              w_incrementa = 1'b1;
              w_proximo    = PROXIMO;
            end
          end else begin
            w_conta = 1'b1;
          end
        end
        PROXIMO: begin
          w_captura = 1'b1;
          w_proximo = ACENDE;
        end
        FIM:     w_proximo = INICIAL;
        default: w_proximo = INICIAL;
      endcase
    end
  end

  // Length and address are frozen at start so later limite changes are ignored.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_endereco <= 4'd0;
      r_limite   <= 4'd0;
      r_leds     <= LED_APAGADO;
    end else begin
      if (w_carrega) begin
        r_endereco <= 4'd0;
        r_limite   <= limite;
      end else if (w_incrementa) begin
        r_endereco <= r_endereco + 4'd1;
      end
      if (w_captura) begin
        r_leds <= mem_dado;
      end
    end
  end

  assign mem_endereco = r_endereco;
  assign leds         = (r_estado == ACENDE) ? r_leds : LED_APAGADO;
  assign exibindo     = (r_estado != INICIAL) && (r_estado != FIM);
  assign pronto       = (r_estado == FIM);
  assign db_estado    = r_estado;

endmodule

// File: tb/tb_exibe_sequencia.sv
// Self-checking bench for exibe_sequencia with short timing (T_ON=4, T_OFF=2).
module tb_exibe_sequencia;

   localparam int T_ON  = 4;
   localparam int T_OFF = 2;

   typedef struct {
      logic [3:0] leds;
      logic       pronto;
      logic       exib;
      logic [3:0] est;
      logic [3:0] addr;
   } obs_t;

   typedef struct {
      logic [3:0] lim;
      int         expTotal;
   } vec_t;

   logic       clock;
   logic       reset;
   logic       iniciar;
   logic       parar;
   logic [3:0] limite;
   logic [3:0] mem_dado;
   logic [3:0] mem_endereco;
   logic [3:0] leds;
   logic       exibindo;
   logic       pronto;
   logic [3:0] db_estado;

   logic [3:0] mem [16];
   obs_t       expQ [$];
   int         checks;
   int         errors;

   exibe_sequencia #(.T_ON(T_ON), .T_OFF(T_OFF)) dut (
      .clock        (clock),
      .reset        (reset),
      .iniciar      (iniciar),
      .parar        (parar),
      .limite       (limite),
      .mem_dado     (mem_dado),
      .mem_endereco (mem_endereco),
      .leds         (leds),
      .exibindo     (exibindo),
      .pronto       (pronto),
      .db_estado    (db_estado)
   );

   // Combinational sequence memory seen by the presenter.
   assign mem_dado = mem[mem_endereco];

   // Free-running clock, period 10.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Safety net so the bench can never hang.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic obs_t mkObs(input logic [3:0] l, input logic p, input logic e,
                                  input logic [3:0] s, input logic [3:0] a);
      obs_t o;
      o.leds = l; o.pronto = p; o.exib = e; o.est = s; o.addr = a;
      return o;
   endfunction

   // Behavioural model: expected per-cycle observation after the start edge,
   // built directly from the presentation rules (prepare, on/off per item, step, done).
   task automatic buildTrace(input logic [3:0] lim);
      expQ.delete();
      expQ.push_back(mkObs(4'h0, 1'b0, 1'b1, 4'h1, 4'd0));
      for (int k = 0; k <= int'(lim); k++) begin
         repeat (T_ON)  expQ.push_back(mkObs(mem[k], 1'b0, 1'b1, 4'h2, 4'(k)));
         repeat (T_OFF) expQ.push_back(mkObs(4'h0, 1'b0, 1'b1, 4'h3, 4'(k)));
         if (k < int'(lim)) expQ.push_back(mkObs(4'h0, 1'b0, 1'b1, 4'h4, 4'(k + 1)));
      end
      expQ.push_back(mkObs(4'h0, 1'b1, 1'b0, 4'hF, lim));
      expQ.push_back(mkObs(4'h0, 1'b0, 1'b0, 4'h0, lim));
   endtask

   // Drive all control inputs together.
   task automatic applyStimulus(input logic ini, input logic par, input logic [3:0] lim);
      iniciar = ini;
      parar   = par;
      limite  = lim;
   endtask

   // Compare every observable output against one expected record.
   task automatic checkOutput(input string name, input obs_t e, input bit chkAddr);
      bit bad;
      checks++;
      bad = (leds !== e.leds) || (pronto !== e.pronto) || (exibindo !== e.exib) ||
            (db_estado !== e.est) || (chkAddr && (mem_endereco !== e.addr));
      if (bad) begin
         errors++;
         $display("[TB] FAIL %s: got leds=%b pronto=%b exib=%b est=%h addr=%0d, expected leds=%b pronto=%b exib=%b est=%h addr=%0d",
                  name, leds, pronto, exibindo, db_estado, mem_endereco,
                  e.leds, e.pronto, e.exib, e.est, e.addr);
      end
   endtask

   task automatic checkValue(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Start a presentation from a negedge in INICIAL and compare every cycle with the model.
   // mode 0 keeps limite, 1 forces it to 1 after start, 2 randomizes it after start.
   task automatic runSequence(input logic [3:0] lim, input int mode, input bit hold);
      logic [3:0] nextLim;
      buildTrace(lim);
      applyStimulus(1'b1, 1'b0, lim);
      @(posedge clock);
      for (int i = 0; i < expQ.size(); i++) begin
         @(negedge clock);
         checkOutput($sformatf("trace lim=%0d cyc=%0d", lim, i + 1), expQ[i], 1'b1);
         nextLim = (mode == 1) ? 4'd1 : (mode == 2) ? 4'($urandom) : lim;
         applyStimulus(hold, 1'b0, nextLim);
      end
   endtask

   // Count cycles from the start edge until the pronto cycle.
   task automatic measureRun(input logic [3:0] lim, output int cyc);
      bit found;
      found = 1'b0;
      cyc   = -1;
      applyStimulus(1'b1, 1'b0, lim);
      @(posedge clock);
      for (int c = 1; c <= 500 && !found; c++) begin
         @(negedge clock);
         applyStimulus(1'b0, 1'b0, lim);
         if (pronto === 1'b1) begin
            found = 1'b1;
            cyc   = c;
         end
      end
   endtask

   initial begin
      vec_t vecs [4];
      int   cyc;
      int   prontoCount;
      logic [3:0] rLim;

      checks = 0;
      errors = 0;
      for (int i = 0; i < 16; i++) mem[i] = 4'(1 << (i % 4));
      reset = 1'b1;
      applyStimulus(1'b0, 1'b0, 4'd0);

      vecs[0] = '{lim: 4'd2,  expTotal: 22};
      vecs[1] = '{lim: 4'd0,  expTotal: 8};
      vecs[2] = '{lim: 4'd15, expTotal: 113};
      vecs[3] = '{lim: 4'd5,  expTotal: 43};

      @(negedge clock);
      checkOutput("reset held", mkObs(4'h0, 1'b0, 1'b0, 4'h0, 4'd0), 1'b1);
      reset = 1'b0;
      @(negedge clock);
      checkOutput("after reset", mkObs(4'h0, 1'b0, 1'b0, 4'h0, 4'd0), 1'b1);

      // Table: total latency to pronto, then pronto must drop after one cycle.
      foreach (vecs[v]) begin
         measureRun(vecs[v].lim, cyc);
         checkValue($sformatf("latency lim=%0d", vecs[v].lim), cyc, vecs[v].expTotal);
         @(negedge clock);
         checkOutput($sformatf("pronto single lim=%0d", vecs[v].lim),
                     mkObs(4'h0, 1'b0, 1'b0, 4'h0, vecs[v].lim), 1'b1);
      end

      // Full traces for the documented cases.
      runSequence(4'd2, 0, 1'b0);
      runSequence(4'd0, 0, 1'b0);
      runSequence(4'd15, 0, 1'b0);
      runSequence(4'd3, 1, 1'b0);

      // Abort during the second lit item, then restart from item 0.
      applyStimulus(1'b1, 1'b0, 4'd2);
      @(posedge clock);
      for (int c = 1; c <= 10; c++) begin
         @(negedge clock);
         applyStimulus(1'b0, 1'b0, 4'd2);
      end
      checkOutput("2nd ACENDE before parar", mkObs(4'b0010, 1'b0, 1'b1, 4'h2, 4'd1), 1'b1);
      applyStimulus(1'b0, 1'b1, 4'd2);
      @(negedge clock);
      checkOutput("after parar", mkObs(4'h0, 1'b0, 1'b0, 4'h0, 4'd0), 1'b0);
      applyStimulus(1'b0, 1'b0, 4'd2);
      prontoCount = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clock);
         if (pronto === 1'b1) prontoCount++;
      end
      checkValue("no pronto after parar", prontoCount, 0);
      checkOutput("idle after parar", mkObs(4'h0, 1'b0, 1'b0, 4'h0, 4'd0), 1'b0);
      runSequence(4'd2, 0, 1'b0);

      // Asynchronous reset in the middle of the dark gap.
      applyStimulus(1'b1, 1'b0, 4'd1);
      @(posedge clock);
      for (int c = 1; c <= 6; c++) begin
         @(negedge clock);
         applyStimulus(1'b0, 1'b0, 4'd1);
      end
      checkOutput("APAGA before reset", mkObs(4'h0, 1'b0, 1'b1, 4'h3, 4'd0), 1'b1);
      #2 reset = 1'b1;
      #1 checkOutput("async reset immediate", mkObs(4'h0, 1'b0, 1'b0, 4'h0, 4'd0), 1'b1);
      #1 reset = 1'b0;
      @(negedge clock);
      checkOutput("idle after async reset", mkObs(4'h0, 1'b0, 1'b0, 4'h0, 4'd0), 1'b1);

      // parar wins over iniciar in the same cycle.
      applyStimulus(1'b1, 1'b1, 4'd5);
      @(negedge clock);
      checkOutput("iniciar+parar", mkObs(4'h0, 1'b0, 1'b0, 4'h0, 4'd0), 1'b1);
      applyStimulus(1'b0, 1'b0, 4'd5);

      // iniciar held high gives back-to-back presentations.
      runSequence(4'd2, 0, 1'b1);
      runSequence(4'd1, 0, 1'b1);
      applyStimulus(1'b0, 1'b0, 4'd0);
      @(negedge clock);
      checkOutput("idle after back-to-back", mkObs(4'h0, 1'b0, 1'b0, 4'h0, 4'd1), 1'b1);

      // Randomized memory contents, lengths and post-start limite activity.
      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < 16; i++) mem[i] = 4'($urandom);
         rLim = 4'($urandom_range(0, 15));
         runSequence(rLim, $urandom_range(0, 2), 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
